// File: rtl/cordic_angle_reducer_if.sv
// Handshake bundle for cordic_angle_reducer: float angle in, reduced Q2.20 angle out.
// slave = reducer side, master = producer/consumer side.
interface cordic_angle_reducer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] angle_float;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] angle_out;
    logic        negate_out;
    logic        range_err;

    modport slave (
        input  in_valid,
        input  angle_float,
        input  out_ready,
        output in_ready,
        output out_valid,
        output angle_out,
        output negate_out,
        output range_err
    );

    modport master (
        output in_valid,
        output angle_float,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  angle_out,
        input  negate_out,
        input  range_err
    );
endinterface

// File: rtl/cordic_angle_reducer.sv
// Range reduction of an IEEE-754 single angle to [0, pi/2] as Q2.20 plus cosine negate flag.
// Ports: clk, reset (sync, active-high), bus (slave: in_valid/in_ready/angle_float,
// out_valid/out_ready/angle_out/negate_out/range_err).
module cordic_angle_reducer #(
    parameter int MAX_EXP = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    cordic_angle_reducer_if.slave bus
);
    localparam int W  = MAX_EXP + 28;
    localparam int KW = $clog2(MAX_EXP);

    localparam logic [W-1:0] TWO_PI = W'(64'h6487ED51);
    localparam logic [W-1:0] PI     = W'(64'h3243F6A9);
    localparam logic [W-1:0] PI_2   = W'(64'h1921FB54);
    localparam logic [W-1:0] HALF   = W'(64'h80);

    localparam logic [KW-1:0] K_TOP = KW'(MAX_EXP - 3);
    localparam logic [7:0]    E_LIM = 8'(127 + MAX_EXP);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] REDUCE = 3'd2;
    localparam logic [2:0] FOLD   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]    state;
    logic [30:0]   fbits;
    logic [W-1:0]  mag;
    logic          err;
    logic [KW-1:0] k;

    logic          valid_q;
    logic [21:0]   angle_q;
    logic          neg_q;
    logic          err_q;

    logic [7:0]    e;
    logic [W-1:0]  mant_w;
    logic [W-1:0]  unp;
    logic          unp_err;
    logic [W-1:0]  step;
    logic [W-1:0]  m1;
    logic [W-1:0]  m2;
    logic          f_neg;
    logic [W-1:0]  rnd;
    logic          unused;

    assign e       = fbits[30:23];
    assign mant_w  = {{(W-24){1'b0}}, 1'b1, fbits[22:0]};
    assign unp_err = (e >= E_LIM);

    // Place the 24-bit significand on the Q.28 grid: bit 23 weighs 2^(e-127),
    // so the shift is e-122; right shifts truncate to zero naturally.
    always_comb begin
        unp = '0;
        if (e != 8'd0 && !unp_err) begin
            if (e >= 8'd122)
                unp = mant_w << (e - 8'd122);
            else
                unp = mant_w >> (8'd122 - e);
        end
    end

    assign step = TWO_PI << k;

    // Fold [0,2pi) onto [0,pi], then onto [0,pi/2] using cos(pi-x) = -cos(x).
    always_comb begin
        m1    = (mag > PI) ? (TWO_PI - mag) : mag;
        f_neg = (m1 > PI_2);
        m2    = f_neg ? (PI - m1) : m1;
        rnd   = m2 + HALF;
    end

    assign unused = ^{bus.angle_float[31], rnd[W-1:30], rnd[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            fbits   <= '0;
            mag     <= '0;
            err     <= 1'b0;
            k       <= '0;
            valid_q <= 1'b0;
            angle_q <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        fbits <= bus.angle_float[30:0];
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    mag   <= unp;
                    err   <= unp_err;
                    k     <= K_TOP;
                    state <= REDUCE;
                end
                REDUCE: begin
                    if (mag >= step)
                        mag <= mag - step;
                    if (k == '0)
                        state <= FOLD;
                    else
                        k <= k - 1'b1;
                end
                FOLD: begin
                    angle_q <= rnd[29:8];
                    neg_q   <= f_neg;
                    err_q   <= err;
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE) && !reset;
    assign bus.out_valid  = valid_q;
    assign bus.angle_out  = angle_q;
    assign bus.negate_out = neg_q;
    assign bus.range_err  = err_q;
endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed bench for cordic_angle_reducer: hand-computed reductions, latency,
// range errors, back-pressure and mid-operation reset.
module tb_cordic_angle_reducer;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   lat;
    logic [21:0] held_angle;

    cordic_angle_reducer_if bus();

    cordic_angle_reducer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one angle, return the number of edges from acceptance to out_valid.
    task automatic send(input logic [31:0] a, output int l);
        @(negedge clk);
        chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid    = 1'b1;
        bus.angle_float = a;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        l = 0;
        while (!bus.out_valid && l < 40) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [21:0] ea, input logic en, input logic ee);
        int l;
        send(a, l);
        chk({tag, "_latency"}, l, 32'd7);
        chk({tag, "_angle"}, {10'd0, bus.angle_out}, {10'd0, ea});
        chk({tag, "_negate"}, {31'd0, bus.negate_out}, {31'd0, en});
        chk({tag, "_err"}, {31'd0, bus.range_err}, {31'd0, ee});
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.angle_float = '0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_angle", {10'd0, bus.angle_out}, 32'd0);
        chk("rst_negate", {31'd0, bus.negate_out}, 32'd0);
        chk("rst_err", {31'd0, bus.range_err}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        run("zero",    32'h00000000, 22'h000000, 1'b0, 1'b0);
        run("one",     32'h3F800000, 22'h100000, 1'b0, 1'b0);
        run("neg_two", 32'hC0000000, 22'h1243F7, 1'b1, 1'b0);
        run("pi",      32'h40490FDB, 22'h000000, 1'b1, 1'b0);
        run("hundred", 32'h42C80000, 22'h087ED5, 1'b0, 1'b0);
        run("three",   32'h40400000, 22'h0243F7, 1'b1, 1'b0);
        run("four",    32'h40800000, 22'h0DBC09, 1'b1, 1'b0);
        run("tiny",    32'h3C000000, 22'h002000, 1'b0, 1'b0);
        run("denorm",  32'h00000001, 22'h000000, 1'b0, 1'b0);
        run("neg_zero",32'h80000000, 22'h000000, 1'b0, 1'b0);
        run("two_hun", 32'h43480000, 22'h000000, 1'b0, 1'b1);
        run("inf",     32'h7F800000, 22'h000000, 1'b0, 1'b1);
        run("nan",     32'h7FC00000, 22'h000000, 1'b0, 1'b1);

        // Back-pressure: hold result for 5 cycles, offered inputs ignored.
        bus.out_ready = 1'b0;
        send(32'h3F800000, lat);
        chk("bp_latency", lat, 32'd7);
        held_angle = bus.angle_out;
        chk("bp_angle", {10'd0, held_angle}, 32'h00100000);
        bus.in_valid    = 1'b1;
        bus.angle_float = 32'hC0000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold", {10'd0, bus.angle_out}, 32'h00100000);
            chk("bp_negate", {31'd0, bus.negate_out}, 32'd0);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // Reset while in REDUCE discards the operation.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.angle_float = 32'h42C80000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready_hi", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_result", {31'd0, bus.out_valid}, 32'd0);
        run("after_rst", 32'h3F800000, 22'h100000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
